// File: rtl/sparserdes_sched.sv
`default_nettype none
// ============================================================================
// Module   : sparserdes_sched
// Brief    : Round-robin scheduler sharing one sparserdes core among NREQ
//            requesters. Optional WAIT watchdog: SPARSERDES_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sparserdes_sched #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic [2:0]               core_instr,
  output logic [ADDR_W-1:0]        core_addr,
  input  logic                     core_done
);

  localparam int         c_gw    = $clog2(NREQ);
  localparam logic [2:0] c_nop   = 3'b000;
  localparam logic [2:0] c_load  = 3'b001;
  localparam logic [2:0] c_send  = 3'b010;
  localparam logic [2:0] c_abort = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_ACK  = 3'd4,
    S_ABRT = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [c_gw-1:0]     gnt_q, gnt_d;
  logic [c_gw-1:0]     last_q, last_d;
  logic [2:0]          instr_q, instr_d;
  logic [ADDR_W-1:0]   caddr_q, caddr_d;

  logic [c_gw-1:0]     w_pick;
  logic [ADDR_W-1:0]   w_pick_addr;
  logic [NREQ-1:0]     w_gnt_oh;
  int                  w_best;
  int                  w_dist;

  // Priority distance from last_q+1; the smallest distance among active
  // requests wins, which gives round-robin order.
  always_comb begin
    w_pick      = '0;
    w_pick_addr = '0;
    w_best      = NREQ;
    w_dist      = 0;
    for (int j = 0; j < NREQ; j++) begin
      w_gnt_oh[j] = (gnt_q == c_gw'(j));
      if (req[j]) begin
        w_dist = (j + NREQ - 1 - int'(last_q)) % NREQ;
        if (w_dist < w_best) begin
          w_best      = w_dist;
          w_pick      = c_gw'(j);
          w_pick_addr = addr[j*ADDR_W +: ADDR_W];
        end
      end
    end
  end

`ifdef SPARSERDES_SCHED_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    gnt_d   = gnt_q;
    last_d  = last_q;
    instr_d = c_nop;
    caddr_d = '0;
`ifdef SPARSERDES_SCHED_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_LOAD;
          gnt_d   = w_pick;
          instr_d = c_load;
          caddr_d = w_pick_addr;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
        instr_d = c_send;
      end
      S_SEND: begin
        state_d = S_WAIT;
`ifdef SPARSERDES_SCHED_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (core_done) begin
          state_d = S_ACK;
          ack_d   = w_gnt_oh;
        end
`ifdef SPARSERDES_SCHED_TIMEOUT_EN
        else if (wdog_q == 8'(TIMEOUT - 1)) begin
          state_d = S_ABRT;
          instr_d = c_abort;
        end else begin
          wdog_d  = wdog_q + 8'd1;
        end
      end
      S_ABRT: begin
        state_d = S_ACK;
        ack_d   = w_gnt_oh;
        err_d   = 1'b1;
`endif
      end
      S_ACK: begin
        state_d = S_IDLE;
        last_d  = gnt_q;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      last_q  <= c_gw'(NREQ - 1);
      instr_q <= c_nop;
      caddr_q <= '0;
`ifdef SPARSERDES_SCHED_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      instr_q <= instr_d;
      caddr_q <= caddr_d;
`ifdef SPARSERDES_SCHED_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign busy       = busy_q;
  assign gnt_id     = gnt_q;
  assign core_instr = instr_q;
  assign core_addr  = caddr_q;
`ifdef SPARSERDES_SCHED_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sparserdes_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparserdes_sched
// Brief    : Directed self-checking bench for sparserdes_sched (NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparserdes_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] addr;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic [1:0]  gnt_id;
  logic [2:0]  core_instr;
  logic [2:0]  core_addr;
  logic        core_done;

  int n_checks = 0;
  int n_errors = 0;

  sparserdes_sched #(.NREQ(4), .ADDR_W(3), .TIMEOUT(15)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .addr       (addr),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .gnt_id     (gnt_id),
    .core_instr (core_instr),
    .core_addr  (core_addr),
    .core_done  (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Requester addresses: a0=5, a1=2, a2=6, a3=3
  int exp_addr[4] = '{5, 2, 6, 3};

  initial begin
    rst_n = 1'b0; req = '0; core_done = 1'b0;
    addr  = {3'd3, 3'd6, 3'd2, 3'd5};
    step(); step();
    check("rst_ack",   ack, 0);
    check("rst_err",   err, 0);
    check("rst_busy",  busy, 0);
    check("rst_gnt",   gnt_id, 0);
    check("rst_instr", core_instr, 0);
    check("rst_caddr", core_addr, 0);

    // Single transfer, requester 0, done in cycle 3
    rst_n = 1'b1; req = 4'b0001;
    step();
    check("t1_c1_instr", core_instr, 3'b001);
    check("t1_c1_caddr", core_addr, 5);
    check("t1_c1_gnt",   gnt_id, 0);
    check("t1_c1_busy",  busy, 1);
    step();
    check("t1_c2_instr", core_instr, 3'b010);
    check("t1_c2_caddr", core_addr, 0);
    step();
    check("t1_c3_instr", core_instr, 3'b000);
    check("t1_c3_ack",   ack, 0);
    core_done = 1'b1;
    step();
    check("t1_c4_ack",   ack, 4'b0001);
    check("t1_c4_err",   err, 0);
    check("t1_c4_instr", core_instr, 0);
    req = '0; core_done = 1'b0;
    step();
    check("t1_c5_busy",  busy, 0);
    check("t1_c5_ack",   ack, 0);

    // All requesting, done held: round-robin from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 4'hF; core_done = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      check("rr_gnt",   gnt_id, n % 4);
      check("rr_caddr", core_addr, exp_addr[n % 4]);
      step(); step(); step();
      check("rr_ack",   ack, 32'(1 << (n % 4)));
      step();
      check("rr_ack_clr", ack, 0);
    end
    req = '0; core_done = 1'b0;
    step();
    check("rr_idle_busy", busy, 0);

    // Requester 2, req dropped after grant, done in cycle 6
    req = 4'b0100;
    for (int c = 1; c <= 7; c++) begin
      step();
      check("t3_busy", busy, 1);
      if (c == 1) begin
        check("t3_gnt", gnt_id, 2);
        req = '0;
      end
      if (c < 7) check("t3_no_ack", ack, 0);
      if (c == 6) core_done = 1'b1;
      if (c == 7) check("t3_ack", ack, 4'b0100);
    end
    core_done = 1'b0;
    step();
    check("t3_c8_busy", busy, 0);

    // core_done high from cycle 0 is ignored before WAIT
    req = 4'b0001; core_done = 1'b1;
    step();
    check("t6_c1_instr", core_instr, 3'b001);
    step();
    check("t6_c2_instr", core_instr, 3'b010);
    step();
    check("t6_c3_ack",   ack, 0);
    check("t6_c3_instr", core_instr, 0);
    step();
    check("t6_c4_ack",   ack, 4'b0001);
    req = '0; core_done = 1'b0;
    step();

    // No core_done: watchdog behaviour
    req = 4'b0001;
    step(); step(); step();
    req = '0;
`ifdef SPARSERDES_SCHED_TIMEOUT_EN
    for (int c = 4; c <= 17; c++) begin
      step();
      check("wd_wait", {busy, err, core_instr, ack}, {1'b1, 1'b0, 3'b000, 4'b0000});
    end
    step();
    check("wd_abort_instr", core_instr, 3'b111);
    check("wd_abort_ack",   ack, 0);
    step();
    check("wd_ack", ack, 4'b0001);
    check("wd_err", err, 1);
    check("wd_ack_instr", core_instr, 0);
    step();
    check("wd_err_clr", err, 0);
    check("wd_idle",    busy, 0);
`else
    for (int c = 4; c <= 22; c++) begin
      step();
      check("nowd_wait", {busy, err, core_instr, ack}, {1'b1, 1'b0, 3'b000, 4'b0000});
    end
    core_done = 1'b1;
    step();
    check("nowd_ack", ack, 4'b0001);
    check("nowd_err", err, 0);
    core_done = 1'b0;
    step();
`endif

    // Async reset during WAIT of requester 2, then req=0110
    req = 4'b0100;
    step();
    check("t5_gnt", gnt_id, 2);
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_busy",  busy, 0);
    check("t5_rst_gnt",   gnt_id, 0);
    check("t5_rst_instr", core_instr, 0);
    check("t5_rst_ack",   ack, 0);
    req = '0; core_done = 1'b1;
    step();
    check("t5_rst_noack", ack, 0);
    step();
    rst_n = 1'b1; req = 4'b0110; core_done = 1'b0;
    step();
    check("t5_gnt_after", gnt_id, 1);
    check("t5_caddr",     core_addr, 2);
    step(); step();
    core_done = 1'b1;
    step();
    check("t5_ack", ack, 4'b0010);
    req = '0; core_done = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sparserdes_sched.md
SPARSERDES_SCHED -- requirements
Module: sparserdes_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one sparserdes core, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 3: core address width.
REQ-003 SHALL have parameter TIMEOUT, default 15: WAIT-state watchdog limit in cycles, 1..255.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, NREQ: per-requester transfer request, level, held until ack.
REQ-007 SHALL have port addr, input, NREQ*ADDR_W: requester i address in bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port ack, output, NREQ: one-cycle completion pulse to granted requester.
REQ-009 SHALL have port err, output, 1: one-cycle pulse coincident with ack when the transfer timed out.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port gnt_id, output, $clog2(NREQ): index of current or last granted requester.
REQ-012 SHALL have port core_instr, output, 3: instruction to core; NOP=000, LOAD=001, SEND=010, ABORT=111.
REQ-013 SHALL have port core_addr, output, ADDR_W: address to core, valid during LOAD.
REQ-014 SHALL have port core_done, input, 1: core completion flag, level.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SEND, WAIT, ACK; all outputs registered.
REQ-016 IDLE: if any req bit set, SHALL grant round-robin starting at (last_gnt+1) mod NREQ, latch gnt_id and its addr, go to LOAD; else stay.
REQ-017 LOAD: SHALL drive core_instr=LOAD, core_addr=latched addr for exactly one cycle, then SEND.
REQ-018 SEND: SHALL drive core_instr=SEND for exactly one cycle, then WAIT.
REQ-019 WAIT: SHALL drive core_instr=NOP; on core_done=1 go to ACK.
REQ-020 ACK: SHALL assert ack[gnt_id] for one cycle, update last_gnt=gnt_id, return to IDLE; no arbitration in ACK.
REQ-021 Latency: req seen in IDLE cycle 0 -> LOAD cycle 1, SEND cycle 2, WAIT from cycle 3; core_done in cycle k>=3 -> ack in cycle k+1; minimum req-to-ack 4 cycles.
REQ-022 core_done SHALL be ignored outside WAIT.
REQ-023 req deassertion after grant SHALL NOT abort the transfer; it completes and acks.
REQ-024 A req still high in the IDLE cycle after ack SHALL be treated as a new request (requester drops req on seeing ack).
REQ-025 core_instr SHALL be NOP and core_addr 0 in IDLE and ACK.
REQ-026 Round-robin SHALL guarantee each continuously-requesting requester a grant within NREQ transfers.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, ack=0, err=0, busy=0, gnt_id=0, last_gnt=NREQ-1 (so requester 0 wins first), core_instr=NOP, core_addr=0, watchdog=0.
REQ-028 Reset mid-transfer SHALL drop the transfer without ack; first post-reset grant follows REQ-016 from last_gnt=NREQ-1.

Configuration
REQ-029 With macro SPARSERDES_SCHED_TIMEOUT_EN defined: watchdog counts WAIT cycles; on reaching TIMEOUT without core_done, SHALL drive core_instr=ABORT for one cycle (WAIT exit), then ACK with err=1; counter clears on WAIT entry.
REQ-030 Without SPARSERDES_SCHED_TIMEOUT_EN: no counter logic; WAIT lasts until core_done; err tied 0; ABORT never issued.

Verification
REQ-031 Reset release, req=0001, addr0=5, core_done high at cycle 3 -> LOAD/addr 5 cycle 1, SEND cycle 2, ack=0001 cycle 4, err=0.
REQ-032 req=1111 held, core_done immediate each transfer -> grant order 0,1,2,3,0; each ack one cycle.
REQ-033 req=0100 granted, req dropped in cycle 1, done at cycle 6 -> ack=0100 cycle 7; busy high cycles 1-7.
REQ-034 TIMEOUT_EN, TIMEOUT=15, core_done never asserted -> ABORT issued after 15 WAIT cycles, then ack+err one cycle; without macro FSM stays in WAIT, err=0.
REQ-035 rst_n pulsed low during WAIT of requester 2 -> outputs reset asynchronously, no ack; req=0110 after release -> requester 1 granted first.
REQ-036 core_done=1 held from cycle 0 -> ignored in IDLE/LOAD/SEND; ack still in cycle 4.
